// File: rtl/fp_sqrt_arbiter_pkg.sv
// Shared types for the square-root arbiter: FP exception flags and the sequencing FSM states.
package fp_sqrt_arbiter_pkg;

  // RISC-V fflags ordering: invalid, divide-by-zero, overflow, underflow, inexact.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRespond
  } fp_sqrt_arb_state_e;

endpackage

// File: rtl/fp_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module fp_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one multi-cycle square-root unit between NUM_REQ requesters with round-robin
// arbitration, holding the unit's operand stable and returning the result to the owner.
module fp_sqrt_arbiter
  import fp_sqrt_arbiter_pkg::*;
#(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned FRACTION_WIDTH = 23,
  parameter int unsigned WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
  parameter int unsigned NUM_REQ        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_src,
  input  logic [NUM_REQ-1:0][2:0]         req_rounding_mode,
  input  logic [NUM_REQ-1:0]              req_flush,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [WIDTH-1:0]                resp_result,
  output fflags_t                         resp_flags,
  output logic                            sqrt_enable,
  output logic                            sqrt_flush,
  output logic [WIDTH-1:0]                sqrt_src,
  output logic [2:0]                      sqrt_rounding_mode,
  input  logic [WIDTH-1:0]                sqrt_result,
  input  fflags_t                         sqrt_flags,
  input  logic                            sqrt_done
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fp_sqrt_arb_state_e state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0]   src_q, src_d;
  logic [2:0]         rm_q, rm_d;
  logic [WIDTH-1:0]   result_q, result_d;
  fflags_t            flags_q, flags_d;

  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic               grant_any;
  logic               owner_flush;
  logic [IdxW-1:0]    ptr_after_owner;

  fp_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .eligible  (req_valid & ~req_flush),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign owner_flush     = req_flush[owner_q];
  assign ptr_after_owner = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign sqrt_src           = src_q;
  assign sqrt_rounding_mode = rm_q;
  assign resp_result        = result_q;
  assign resp_flags         = flags_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    src_d       = src_q;
    rm_d        = rm_q;
    result_d    = result_q;
    flags_d     = flags_q;
    req_ready   = '0;
    resp_valid  = '0;
    sqrt_enable = 1'b0;
    sqrt_flush  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no requester sees a grant while reset is held.
        if (grant_any && rst_n) begin
          req_ready = grant;
          owner_d   = grant_idx;
          src_d     = req_src[grant_idx];
          rm_d      = req_rounding_mode[grant_idx];
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // A flush beats a coincident sqrt_done; the result is simply not captured.
        if (owner_flush) begin
          sqrt_flush = 1'b1;
          ptr_d      = ptr_after_owner;
          state_d    = StIdle;
        end else begin
          sqrt_enable = 1'b1;
          if (sqrt_done) begin
            result_d = sqrt_result;
            flags_d  = sqrt_flags;
            state_d  = StRespond;
          end
        end
      end
      StRespond: begin
        if (owner_flush) begin
          ptr_d   = ptr_after_owner;
          state_d = StIdle;
        end else begin
          resp_valid[owner_q] = 1'b1;
          if (resp_ready[owner_q]) begin
            ptr_d   = ptr_after_owner;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      src_q    <= '0;
      rm_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      src_q    <= src_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: doc/fp_sqrt_arbiter.md
# fp_sqrt_arbiter

Shares one multi-cycle square-root datapath (the FpSqrtUnit instance in the FPU) between NUM_REQ requesters, e.g. two issue slots or two harts. It round-robin arbitrates requests, latches the winning operand and rounding mode, and drives the unit's enable/flush/src for the whole computation. It then returns the result and fflags to the owning requester over a valid/ready handshake. The unit is external; this block only sequences it.

## Interface
Parameters:
- EXPONENT_WIDTH, 8, exponent field width
- FRACTION_WIDTH, 23, fraction field width
- WIDTH, 1+EXPONENT_WIDTH+FRACTION_WIDTH, FP word width (derived)
- NUM_REQ, 2, number of requesters (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- reqValid  in  NUM_REQ  request pending per requester
- reqReady  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- reqSrc  in  NUM_REQ×WIDTH  operand per requester
- reqRoundingMode  in  NUM_REQ×3  rounding mode per requester
- reqFlush  in  NUM_REQ  cancel this requester's pending/in-flight op
- respValid  out  NUM_REQ  result valid for owner (one-hot or zero)
- respReady  in  NUM_REQ  requester takes result
- respResult  out  WIDTH  registered result
- respFlags  out  fflags_t  registered flags
- sqrtEnable / sqrtFlush  out  1  drive unit enable / flush
- sqrtSrc  out  WIDTH; sqrtRoundingMode  out  3  latched operand to unit
- sqrtResult  in  WIDTH; sqrtFlags  in  fflags_t; sqrtDone  in  1  unit outputs

## Operation
- FSM states: IDLE, BUSY, RESPOND.
- IDLE: eligible(i) = reqValid[i] & ~reqFlush[i]. Winner = first eligible at or after priority pointer ptr, wrapping. reqReady[winner]=1 combinationally. On accept: latch src, rm, owner id → BUSY. No eligible → stay.
- BUSY: sqrtEnable=1 continuously; sqrtSrc/sqrtRoundingMode from latches, stable. sqrtDone=1 → capture sqrtResult/sqrtFlags into resp regs → RESPOND.
- RESPOND: respValid[owner]=1, sqrtEnable=0. respReady[owner]=1 → ptr=(owner+1) mod NUM_REQ → IDLE. respReady of non-owners ignored.
- Flush, owner, BUSY: sqrtFlush=1, sqrtEnable=0 that cycle; → IDLE; no response; ptr advances past owner.
- Flush, owner, RESPOND: response dropped (respValid=0 same cycle) → IDLE.
- Flush of non-owner outside IDLE: ignored.
- Flush and sqrtDone same cycle: flush wins, result discarded.
- Flush and respReady same cycle: treat as flush; same next state.
- reqReady is never asserted outside IDLE. A requester holds reqValid/reqSrc stable until reqReady.
- ptr advances only on completion or flush of an accepted op.

## Timing
- Reset (rst=0, async): state=IDLE, ptr=0, owner=0, latches=0, respResult=0, respFlags=0. All outputs 0 during and immediately after reset.
- Reset mid-BUSY aborts with no sqrtFlush pulse. The unit shares rst.
- Accept at cycle T. sqrtEnable high from T+1. sqrtDone at T+1+L (L = unit latency). respValid from T+2+L, held until handshake.
- RESPOND→IDLE costs one cycle. sqrtEnable is low ≥1 cycle between ops.
- Max throughput: one op per L+3 cycles.
- respResult/respFlags are stable while respValid is high.

## Structure
- fflags_t comes from the existing shared type package. Add an FSM state typedef (FpSqrtArbState: IDLE, BUSY, RESPOND) to the FPU types package.
- One sub-module: fp_rr_picker. Inputs: eligible vector and ptr. Outputs: one-hot grant and index. Purely combinational, parameterised by NUM_REQ.
- The bench connects a real FpSqrtUnit to the sqrt* ports.

## Test plan
- Single op: req0 src=0x40800000 (4.0), rm=0 → respValid[0] after L+2 cycles, respResult=0x40000000, flags=0. req1 never sees respValid.
- Contention from reset: req0=0x40800000 and req1=0x41100000 (9.0) in the same cycle → req0 served first (0x40000000), then req1 (0x40400000). Swap the order next round to check ptr.
- Invalid operand: src=0xBF800000 (−1.0) → respResult=0x7FC00000, flags.NV=1.
- Flush mid-BUSY: reqFlush[owner] at accept+3 → sqrtFlush pulse of exactly 1 cycle, no respValid, IDLE next cycle. A new req succeeds with the correct result.
- Backpressure: hold respReady[0]=0 for 10 cycles → respValid and respResult stable, req1 reqReady stays 0. Release → completes, then req1 accepted.
- Async reset: drive rst=0 in BUSY between clock edges → all outputs 0 immediately. After release, the first request completes correctly.
